// File: rtl/uart_rx_fifo_axis.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO that is read as an AXI-Stream master.
// A byte is visible one cycle after its stop-bit sample; backpressure only fills the FIFO, and a full FIFO drops new bytes.

module uart_rx_fifo_axis_fifo #(
   parameter int DW    = 9,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_wr_vld,
   input  logic [DW-1:0]          i_wr_dat,
   output logic                   o_wr_rdy,
   output logic                   o_rd_vld,
   output logic [DW-1:0]          o_rd_dat,
   input  logic                   i_rd_rdy,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_rd;
   logic          w_wr;

   assign o_rd_vld = (r_count != '0);
   assign w_rd     = o_rd_vld && i_rd_rdy;
   // A full FIFO still takes a write when the head leaves in the same cycle
   assign o_wr_rdy = (r_count != FULL) || w_rd;
   assign w_wr     = i_wr_vld && o_wr_rdy;
   assign o_rd_dat = o_rd_vld ? r_mem[r_rd_ptr] : '0;
   assign o_count  = r_count;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module uart_rx_fifo_axis #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 8,
   parameter int               CLK_RATE  = 100000000,
   parameter int               BAUD      = 115200,
   parameter logic [WIDTH-1:0] LAST_BYTE = 8'h0A
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   uart_rx,
   output logic [WIDTH-1:0]       m_axis_data,
   output logic                   m_axis_valid,
   input  logic                   m_axis_ready,
   output logic                   m_axis_last,
   output logic                   frame_err,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   logic [1:0]       r_fill;
   logic             r_armed;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    w_idx_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic             r_frame_err;
   logic             r_overflow;
   logic             w_fall;
   logic             w_stop_good;
   logic             w_stop_bad;
   logic             w_wr_rdy;
   logic [WIDTH:0]   w_wr_dat;
   logic [WIDTH:0]   w_rd_dat;

   // r_fill marks when r_sync2 holds a real line sample; a line held low
   // through reset must be seen high once before any edge can count.
   assign w_fall = r_armed && r_prev && !r_sync2;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_stop_good = 1'b0;
      w_stop_bad  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (w_fall) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = r_sync2;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_idx_nxt = r_idx + IW'(1);
               end
            end
         end
         S_STOP: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
               w_stop_good = r_sync2;
               w_stop_bad  = !r_sync2;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_prev      <= 1'b1;
         r_fill      <= '0;
         r_armed     <= 1'b0;
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_sync1     <= uart_rx;
         r_sync2     <= r_sync1;
         r_prev      <= r_sync2;
         r_fill      <= {r_fill[0], 1'b1};
         r_armed     <= r_armed || (r_fill[1] && r_sync2);
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_frame_err <= w_stop_bad;
         r_overflow  <= w_stop_good && !w_wr_rdy;
      end
   end

   assign w_wr_dat = {(r_shift == LAST_BYTE), r_shift};

   uart_rx_fifo_axis_fifo #(
      .DW    (WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_wr_vld (w_stop_good),
      .i_wr_dat (w_wr_dat),
      .o_wr_rdy (w_wr_rdy),
      .o_rd_vld (m_axis_valid),
      .o_rd_dat (w_rd_dat),
      .i_rd_rdy (m_axis_ready),
      .o_count  (fifo_count)
   );

   assign m_axis_data = w_rd_dat[WIDTH-1:0];
   assign m_axis_last = w_rd_dat[WIDTH];
   assign frame_err   = r_frame_err;
   assign overflow    = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo_axis.sv
// Bench for uart_rx_fifo_axis: drives 8N1 frames at 32 clocks per bit and compares AXIS output against a queue model.

module tb_uart_rx_fifo_axis;
   localparam int CPB   = 32;
   localparam int DEPTH = 8;
   // posedges from the start-bit drive edge to the stop-sample cycle:
   // two synchroniser flops plus the edge register, half a bit, nine bits
   localparam int STOP_W = 2 + CPB/2 + 9*CPB;
   localparam int LAT    = STOP_W + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rx;
   logic [7:0] m_axis_data;
   logic       m_axis_valid;
   logic       m_axis_ready;
   logic       m_axis_last;
   logic       frame_err;
   logic       overflow;
   logic [3:0] fifo_count;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [8:0] got_q[$];
   int         got_cyc[$];
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         vld_cycles = 0;
   int         hold_viol = 0;
   logic       prev_stall = 1'b0;
   logic [8:0] prev_beat = '0;

   uart_rx_fifo_axis #(
      .WIDTH     (8),
      .DEPTH     (DEPTH),
      .CLK_RATE  (CPB * 1000),
      .BAUD      (1000),
      .LAST_BYTE (8'h0A)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_rx      (uart_rx),
      .m_axis_data  (m_axis_data),
      .m_axis_valid (m_axis_valid),
      .m_axis_ready (m_axis_ready),
      .m_axis_last  (m_axis_last),
      .frame_err    (frame_err),
      .overflow     (overflow),
      .fifo_count   (fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!m_axis_valid || {m_axis_last, m_axis_data} !== prev_beat)) hold_viol++;
         if (m_axis_valid) vld_cycles++;
         if (m_axis_valid && m_axis_ready) begin
            got_q.push_back({m_axis_last, m_axis_data});
            got_cyc.push_back(cyc);
         end
         if (frame_err) fe_cnt++;
         if (overflow) ov_cnt++;
         prev_stall = m_axis_valid && !m_axis_ready;
         prev_beat  = {m_axis_last, m_axis_data};
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic rnd_rdy, output int t0);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      t0 = 0;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < CPB; c++) begin
            @(posedge clk); #1;
            if (c == 0) uart_rx = fr[i];
            if (i == 0 && c == 0) t0 = cyc;
            if (rnd_rdy) m_axis_ready = ($urandom_range(3) != 0);
         end
      end
      @(posedge clk); #1;
      uart_rx = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; uart_rx = 1'b1; m_axis_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_axis_valid); end
      checks++; if (m_axis_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_axis_data); end
      checks++; if (m_axis_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", m_axis_last); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      repeat (CPB) @(posedge clk);
   endtask

   task automatic test_single_byte();
      int t0, gb, fb, vb;
      gb = got_q.size(); fb = fe_cnt; vb = vld_cycles;
      m_axis_ready = 1'b1;
      send_frame(8'h55, 1'b1, 1'b0, t0);
      repeat (CPB) @(posedge clk);
      @(negedge clk);
      checks++; if (got_q.size() - gb !== 1) begin errors++; $display("FAIL single_beats: got %0d want 1", got_q.size() - gb); end
      if (got_q.size() > gb) begin
         checks++; if (got_q[gb] !== 9'h055) begin errors++; $display("FAIL single_beat: got %h want 055", got_q[gb]); end
         checks++; if (got_cyc[gb] - t0 !== LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", got_cyc[gb] - t0, LAT); end
      end
      checks++; if (vld_cycles - vb !== 1) begin errors++; $display("FAIL single_valid_cycles: got %0d want 1", vld_cycles - vb); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count: got %0d want 0", fifo_count); end
      checks++; if (fe_cnt - fb !== 0) begin errors++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt - fb); end
   endtask

   task automatic test_delimiter();
      int t0, gb, fb;
      logic [8:0] exp_b [2];
      exp_b[0] = 9'h041; exp_b[1] = 9'h10A;
      gb = got_q.size(); fb = fe_cnt;
      m_axis_ready = 1'b1;
      send_frame(8'h41, 1'b1, 1'b0, t0);
      send_frame(8'h0A, 1'b1, 1'b0, t0);
      repeat (CPB) @(posedge clk);
      @(negedge clk);
      checks++; if (got_q.size() - gb !== 2) begin errors++; $display("FAIL delim_beats: got %0d want 2", got_q.size() - gb); end
      for (int k = 0; k < 2; k++) begin
         if (got_q.size() > gb + k) begin
            checks++; if (got_q[gb+k] !== exp_b[k]) begin errors++; $display("FAIL delim_beat%0d: got %h want %h", k, got_q[gb+k], exp_b[k]); end
         end
      end
      checks++; if (fe_cnt - fb !== 0) begin errors++; $display("FAIL delim_frame_err: got %0d want 0", fe_cnt - fb); end
   endtask

   task automatic test_backpressure_overflow();
      logic [8:0] mdl[$];
      logic [8:0] exp_out[$];
      int mdl_ov, gb, ob, t0, t1;
      mdl_ov = 0; gb = got_q.size(); ob = ov_cnt;
      m_axis_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         send_frame(8'(i), 1'b1, 1'b0, t0);
         if (mdl.size() < DEPTH) mdl.push_back({1'b0, 8'(i)}); else mdl_ov++;
         @(negedge clk);
         checks++; if (fifo_count !== 4'(mdl.size())) begin errors++; $display("FAIL bp_count_%0d: got %0d want %0d", i, fifo_count, mdl.size()); end
         checks++; if (ov_cnt - ob !== mdl_ov) begin errors++; $display("FAIL bp_overflow_%0d: got %0d want %0d", i, ov_cnt - ob, mdl_ov); end
      end
      checks++; if (got_q.size() - gb !== 0) begin errors++; $display("FAIL bp_no_beats: got %0d want 0", got_q.size() - gb); end
      // one read handshake lands on the same cycle as the 0x09 write
      fork
         send_frame(8'h09, 1'b1, 1'b0, t1);
         begin
            repeat (STOP_W + 1) @(posedge clk);
            #1 m_axis_ready = 1'b1;
            @(posedge clk);
            #1 m_axis_ready = 1'b0;
         end
      join
      exp_out.push_back(mdl.pop_front());
      mdl.push_back(9'h009);
      @(negedge clk);
      checks++; if (fifo_count !== 4'(mdl.size())) begin errors++; $display("FAIL full_rw_count: got %0d want %0d", fifo_count, mdl.size()); end
      checks++; if (ov_cnt - ob !== mdl_ov) begin errors++; $display("FAIL full_rw_overflow: got %0d want %0d", ov_cnt - ob, mdl_ov); end
      checks++; if (got_q.size() - gb !== 1) begin errors++; $display("FAIL full_rw_beats: got %0d want 1", got_q.size() - gb); end
      while (mdl.size() > 0) exp_out.push_back(mdl.pop_front());
      m_axis_ready = 1'b1;
      repeat (2*DEPTH + 4) @(posedge clk);
      @(negedge clk);
      checks++; if (got_q.size() - gb !== exp_out.size()) begin errors++; $display("FAIL drain_beats: got %0d want %0d", got_q.size() - gb, exp_out.size()); end
      for (int k = 0; k < exp_out.size(); k++) begin
         if (got_q.size() > gb + k) begin
            checks++; if (got_q[gb+k] !== exp_out[k]) begin errors++; $display("FAIL drain_beat%0d: got %h want %h", k, got_q[gb+k], exp_out[k]); end
         end
      end
      checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", m_axis_valid); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", fifo_count); end
   endtask

   task automatic test_frame_error();
      int t0, gb, fb;
      gb = got_q.size(); fb = fe_cnt;
      m_axis_ready = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b0, t0);
      @(negedge clk);
      checks++; if (fe_cnt - fb !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles want 1", fe_cnt - fb); end
      checks++; if (got_q.size() - gb !== 0) begin errors++; $display("FAIL ferr_no_write: got %0d beats want 0", got_q.size() - gb); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL ferr_count: got %0d want 0", fifo_count); end
      send_frame(8'h3C, 1'b1, 1'b0, t0);
      repeat (CPB) @(posedge clk);
      @(negedge clk);
      checks++; if (got_q.size() - gb !== 1) begin errors++; $display("FAIL ferr_next_beats: got %0d want 1", got_q.size() - gb); end
      if (got_q.size() > gb) begin
         checks++; if (got_q[gb] !== 9'h03C) begin errors++; $display("FAIL ferr_next_beat: got %h want 03c", got_q[gb]); end
      end
      checks++; if (fe_cnt - fb !== 1) begin errors++; $display("FAIL ferr_next_fe: got %0d want 1", fe_cnt - fb); end
   endtask

   task automatic test_glitch();
      int t0, gb, fb, g;
      gb = got_q.size(); fb = fe_cnt;
      g = $urandom_range(CPB/2 - 4, 4);
      m_axis_ready = 1'b1;
      @(posedge clk); #1 uart_rx = 1'b0;
      repeat (g) @(posedge clk);
      #1 uart_rx = 1'b1;
      repeat (2*CPB) @(posedge clk);
      @(negedge clk);
      checks++; if (got_q.size() - gb !== 0) begin errors++; $display("FAIL glitch_write: got %0d beats want 0 (low %0d)", got_q.size() - gb, g); end
      checks++; if (fe_cnt - fb !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - fb); end
      send_frame(8'hC3, 1'b1, 1'b0, t0);
      repeat (CPB) @(posedge clk);
      @(negedge clk);
      checks++; if (got_q.size() - gb !== 1) begin errors++; $display("FAIL glitch_next_beats: got %0d want 1", got_q.size() - gb); end
      if (got_q.size() > gb) begin
         checks++; if (got_q[gb] !== 9'h0C3) begin errors++; $display("FAIL glitch_next_beat: got %h want 0c3", got_q[gb]); end
      end
   endtask

   task automatic test_reset_midframe();
      int t0, gb, fb;
      logic [9:0] fr;
      m_axis_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, t0);
      send_frame(8'h22, 1'b1, 1'b0, t0);
      @(negedge clk);
      checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL rstmid_queued: got %0d want 2", fifo_count); end
      fr = {1'b1, 8'h96, 1'b0};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1 uart_rx = fr[i];
         repeat ((i == 5) ? CPB/2 : CPB - 1) @(posedge clk);
      end
      #1 rst = 1'b1; uart_rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
      checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", m_axis_valid); end
      gb = got_q.size(); fb = fe_cnt;
      m_axis_ready = 1'b1;
      repeat (3*CPB) @(posedge clk);
      @(negedge clk);
      checks++; if (got_q.size() - gb !== 0) begin errors++; $display("FAIL rstmid_low_line_beats: got %0d want 0", got_q.size() - gb); end
      checks++; if (fe_cnt - fb !== 0) begin errors++; $display("FAIL rstmid_low_line_fe: got %0d want 0", fe_cnt - fb); end
      @(posedge clk); #1 uart_rx = 1'b1;
      repeat (CPB) @(posedge clk);
      send_frame(8'h96, 1'b1, 1'b0, t0);
      repeat (CPB) @(posedge clk);
      @(negedge clk);
      checks++; if (got_q.size() - gb !== 1) begin errors++; $display("FAIL rstmid_next_beats: got %0d want 1", got_q.size() - gb); end
      if (got_q.size() > gb) begin
         checks++; if (got_q[gb] !== 9'h096) begin errors++; $display("FAIL rstmid_next_beat: got %h want 096", got_q[gb]); end
      end
   endtask

   task automatic test_random_stream();
      logic [8:0] exp_q[$];
      logic [7:0] b;
      logic       good;
      int t0, gb, fb, ob, nfe;
      gb = got_q.size(); fb = fe_cnt; ob = ov_cnt; nfe = 0;
      for (int k = 0; k < 12; k++) begin
         b    = 8'($urandom_range(255));
         good = ($urandom_range(7) != 0);
         if (k == 3) b = 8'h0A;
         if (k == 5) good = 1'b0;
         send_frame(b, good, 1'b1, t0);
         if (good) exp_q.push_back({(b == 8'h0A), b}); else nfe++;
         repeat ($urandom_range(CPB)) begin
            @(posedge clk); #1 m_axis_ready = ($urandom_range(3) != 0);
         end
      end
      m_axis_ready = 1'b1;
      repeat (CPB) @(posedge clk);
      @(negedge clk);
      checks++; if (got_q.size() - gb !== exp_q.size()) begin errors++; $display("FAIL rand_beats: got %0d want %0d", got_q.size() - gb, exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         if (got_q.size() > gb + k) begin
            checks++; if (got_q[gb+k] !== exp_q[k]) begin errors++; $display("FAIL rand_beat%0d: got %h want %h", k, got_q[gb+k], exp_q[k]); end
         end
      end
      checks++; if (fe_cnt - fb !== nfe) begin errors++; $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt - fb, nfe); end
      checks++; if (ov_cnt - ob !== 0) begin errors++; $display("FAIL rand_overflow: got %0d want 0", ov_cnt - ob); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rand_count: got %0d want 0", fifo_count); end
   endtask

   task automatic test_axis_hold();
      checks++; if (hold_viol !== 0) begin errors++; $display("FAIL axis_hold: got %0d stall violations want 0", hold_viol); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_delimiter();
      test_backpressure_overflow();
      test_frame_error();
      test_glitch();
      test_reset_midframe();
      test_random_stream();
      test_axis_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL timeout: run exceeded 80000 cycles, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
